// File: rtl/sha_const.sv
// Shared constants and types for the SHA-1 message padding front end.
package sha_const;

  localparam int BLOCK_W    = 512;
  localparam int WORD_W     = 32;
  localparam int NUM_WORDS  = BLOCK_W / WORD_W;
  localparam int LEN_HI_IDX = 14;
  localparam int LEN_LO_IDX = 15;

  localparam logic [7:0] PAD_MARKER = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    SEND,
    XSEND
  } state_e;

  // Word 0 sits in the most significant 32 bits of the block.
  typedef logic [0:NUM_WORDS-1][WORD_W-1:0] block_t;

endpackage

// File: rtl/sha_pad_mask.sv
// Keeps the first bytes_i bytes of a big-endian word, places the 0x80 marker
// right after them and clears the rest; bytes_i==4 passes the word through.
module sha_pad_mask
  import sha_const::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [2:0]        bytes_i,
  output logic [WORD_W-1:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < bytes_i) begin
        word_o[31-8*i -: 8] = word_i[31-8*i -: 8];
      end else if (3'(i) == bytes_i) begin
        word_o[31-8*i -: 8] = PAD_MARKER;
      end
    end
  end

endmodule

// File: rtl/sha_pad.sv
// Packs a 32-bit word stream into SHA-1 padded 512-bit blocks for the sha_1 core.
// Define SHA_PAD_BSWAP_EN to accept little-endian (byte 0 at [7:0]) input words.
module sha_pad
  import sha_const::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_W-1:0]  In_Data,
  input  logic               In_Valid,
  input  logic               In_Last,
  input  logic [1:0]         In_Bytes,
  output logic               In_Ready,
  output logic [BLOCK_W-1:0] Data,
  output logic               Valid,
  input  logic               Ready,
  output logic               First,
  output logic               Last
);

  state_e      state_q, state_d;
  logic [3:0]  w_q, w_d;
  logic [63:0] len_q, len_d;
  logic        msg_first_q, msg_first_d;
  logic        xpend_q, xpend_d;
  logic        xmark_q, xmark_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  block_t      data_q, data_d;

  logic [WORD_W-1:0] word_in;
  logic [WORD_W-1:0] masked;
  logic [2:0]        nbytes;
  logic [4:0]        p;
  logic [63:0]       len_next;

`ifdef SHA_PAD_BSWAP_EN
  assign word_in = {In_Data[7:0], In_Data[15:8], In_Data[23:16], In_Data[31:24]};
`else
  assign word_in = In_Data;
`endif

  assign nbytes   = (!In_Last || In_Bytes == 2'd0) ? 3'd4 : {1'b0, In_Bytes};
  assign p        = {1'b0, w_q} + ((nbytes == 3'd4) ? 5'd1 : 5'd0);
  assign len_next = len_q + {58'd0, nbytes, 3'd0};

  sha_pad_mask u_mask (
    .word_i  (word_in),
    .bytes_i (nbytes),
    .word_o  (masked)
  );

  assign In_Ready = (state_q == FILL);
  assign Valid    = (state_q != FILL);
  assign Data     = data_q;
  assign First    = first_q;
  assign Last     = last_q;

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    len_d       = len_q;
    msg_first_d = msg_first_q;
    xpend_d     = xpend_q;
    xmark_d     = xmark_q;
    first_d     = first_q;
    last_d      = last_q;
    data_d      = data_q;

    unique case (state_q)
      FILL: begin
        if (In_Valid) begin
          len_d = len_next;
          if (In_Last) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
              if (i == int'(w_q)) begin
                data_d[i] = masked;
              end else if (i > int'(w_q)) begin
                data_d[i] = '0;
              end
            end
            if (nbytes == 3'd4 && w_q != 4'd15) begin
              data_d[w_q + 4'd1] = {PAD_MARKER, 24'd0};
            end
            // Length only fits here if the marker left words 14 and 15 free.
            if (p <= 5'd13) begin
              data_d[LEN_HI_IDX] = len_next[63:32];
              data_d[LEN_LO_IDX] = len_next[31:0];
              last_d  = 1'b1;
              xpend_d = 1'b0;
            end else begin
              last_d  = 1'b0;
              xpend_d = 1'b1;
            end
            xmark_d = (p == 5'd16);
            w_d     = 4'd0;
            first_d = msg_first_q;
            state_d = SEND;
          end else begin
            data_d[w_q] = word_in;
            w_d         = w_q + 4'd1;
            if (w_q == 4'd15) begin
              first_d = msg_first_q;
              last_d  = 1'b0;
              xpend_d = 1'b0;
              state_d = SEND;
            end
          end
        end
      end

      SEND: begin
        if (Ready) begin
          if (xpend_q) begin
            data_d = '0;
            if (xmark_q) begin
              data_d[0] = {PAD_MARKER, 24'd0};
            end
            data_d[LEN_HI_IDX] = len_q[63:32];
            data_d[LEN_LO_IDX] = len_q[31:0];
            first_d = 1'b0;
            last_d  = 1'b1;
            xpend_d = 1'b0;
            state_d = XSEND;
          end else begin
            if (last_q) begin
              len_d       = '0;
              msg_first_d = 1'b1;
            end else begin
              msg_first_d = 1'b0;
            end
            w_d     = 4'd0;
            first_d = 1'b0;
            last_d  = 1'b0;
            state_d = FILL;
          end
        end
      end

      XSEND: begin
        if (Ready) begin
          len_d       = '0;
          msg_first_d = 1'b1;
          w_d         = 4'd0;
          first_d     = 1'b0;
          last_d      = 1'b0;
          state_d     = FILL;
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FILL;
      w_q         <= '0;
      len_q       <= '0;
      msg_first_q <= 1'b1;
      xpend_q     <= 1'b0;
      xmark_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      len_q       <= len_d;
      msg_first_q <= msg_first_d;
      xpend_q     <= xpend_d;
      xmark_q     <= xmark_d;
      first_q     <= first_d;
      last_q      <= last_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_sha_pad.sv
// Self-checking bench for sha_pad: byte-level SHA-1 padding model versus DUT blocks.
module tb_sha_pad;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  In_Data;
  logic         In_Valid;
  logic         In_Last;
  logic [1:0]   In_Bytes;
  logic         In_Ready;
  logic [511:0] Data;
  logic         Valid;
  logic         Ready;
  logic         First;
  logic         Last;

  int errors = 0;
  int checks = 0;

  logic [7:0]   msg_q[$];
  logic [511:0] exp_q[$];

  sha_pad dut (
    .clk      (clk),
    .rst      (rst),
    .In_Data  (In_Data),
    .In_Valid (In_Valid),
    .In_Last  (In_Last),
    .In_Bytes (In_Bytes),
    .In_Ready (In_Ready),
    .Data     (Data),
    .Valid    (Valid),
    .Ready    (Ready),
    .First    (First),
    .Last     (Last)
  );

  always #5 clk = ~clk;

  // Big-endian word as the DUT expects it on its input pins.
  function automatic logic [31:0] present(input logic [31:0] w);
`ifdef SHA_PAD_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Standard SHA-1 padding over the byte string, then cut into 64-byte blocks.
  task automatic build_model();
    logic [7:0]   pad[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    exp_q.delete();
    pad = msg_q;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bits = 64'(msg_q.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) pad.push_back(bits[8*i +: 8]);
    for (int k = 0; k < pad.size() / 64; k++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pad[64*k+j];
      exp_q.push_back(blk);
    end
  endtask

  task automatic rand_msg(input int n);
    msg_q.delete();
    repeat (n) msg_q.push_back(8'($urandom));
  endtask

  task automatic run_message(input int vpct, input int rpct);
    logic [31:0] words[$];
    logic [31:0] w;
    int n, nwords, wi, bi, cyc;
    bit v, r, exp_valid_next;
    n = msg_q.size();
    nwords = (n + 3) / 4;
    build_model();
    for (int k = 0; k < nwords; k++) begin
      w = $urandom;
      for (int j = 0; j < 4; j++)
        if (4*k + j < n) w[31-8*j -: 8] = msg_q[4*k+j];
      words.push_back(w);
    end
    wi = 0; bi = 0; cyc = 0; exp_valid_next = 0;
    while ((wi < nwords || bi < exp_q.size()) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (exp_valid_next) begin
        checks++;
        if (Valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL valid_timing: Valid=%b required 1 (msg len %0d)", Valid, n);
        end
      end
      exp_valid_next = 0;
      checks++;
      if (Valid === 1'b1 && In_Ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ready_excl: In_Ready=%b required 0 while Valid", In_Ready);
      end
      r = ($urandom_range(99) < rpct);
      v = (wi < nwords) && ($urandom_range(99) < vpct);
      Ready    = r;
      In_Valid = v;
      In_Data  = v ? present(words[wi]) : $urandom;
      In_Last  = v && (wi == nwords - 1);
      In_Bytes = (v && wi == nwords - 1) ? 2'(n % 4) : 2'($urandom);
      if (Valid === 1'b1 && r) begin
        if (bi >= exp_q.size()) begin
          checks++; errors++;
          $display("[TB] FAIL extra_block: got block %0d, required only %0d", bi, exp_q.size());
        end else begin
          checks++;
          if (Data !== exp_q[bi]) begin
            errors++;
            $display("[TB] FAIL data blk%0d len%0d: got %h required %h", bi, n, Data, exp_q[bi]);
          end
          checks++;
          if (First !== (bi == 0) || Last !== (bi == exp_q.size() - 1)) begin
            errors++;
            $display("[TB] FAIL flags blk%0d len%0d: got First=%b Last=%b required First=%b Last=%b",
                     bi, n, First, Last, bi == 0, bi == exp_q.size() - 1);
          end
        end
        bi++;
        if (wi == nwords && bi < exp_q.size()) exp_valid_next = 1;
      end
      if (In_Ready === 1'b1 && v) begin
        wi++;
        if (wi == nwords || wi % 16 == 0) exp_valid_next = 1;
      end
    end
    checks++;
    if (cyc >= 3000) begin
      errors++;
      $display("[TB] FAIL timeout: words %0d/%0d blocks %0d/%0d", wi, nwords, bi, exp_q.size());
    end
    @(negedge clk);
    Ready = 1'b0; In_Valid = 1'b0; In_Last = 1'b0;
    checks++;
    if (Valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_msg: Valid=%b required 0", Valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; In_Valid = 1'b0; In_Last = 1'b0; In_Bytes = 2'd0; In_Data = '0; Ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (Valid !== 1'b0 || First !== 1'b0 || Last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got V=%b F=%b L=%b required 0 0 0", Valid, First, Last);
    end
    checks++;
    if (Data !== 512'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h required 0", Data);
    end
    checks++;
    if (In_Ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b required 1", In_Ready);
    end
    rst = 1'b1;
  endtask

  // "abc" with a 10-cycle downstream stall; block is the well-known SHA-1 example.
  task automatic test_abc_stall();
    logic [511:0] abc;
    abc = {32'h61626380, {13{32'h0}}, 32'h0, 32'h00000018};
    @(negedge clk);
    In_Valid = 1'b1; In_Last = 1'b1; In_Bytes = 2'd3; In_Data = present(32'h61626300); Ready = 1'b0;
    @(negedge clk);
    In_Valid = 1'b0; In_Last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (Valid !== 1'b1 || In_Ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hs cyc%0d: got Valid=%b In_Ready=%b required 1 0", c, Valid, In_Ready);
      end
      checks++;
      if (Data !== abc || First !== 1'b1 || Last !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_block cyc%0d: got F=%b L=%b %h required F=1 L=1 %h", c, First, Last, Data, abc);
      end
      @(negedge clk);
    end
    Ready = 1'b1;
    checks++;
    if (Valid !== 1'b1 || Data !== abc) begin
      errors++;
      $display("[TB] FAIL stall_release: got Valid=%b %h required 1 %h", Valid, Data, abc);
    end
    @(negedge clk);
    Ready = 1'b0;
    checks++;
    if (Valid !== 1'b0 || In_Ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_hs: got Valid=%b In_Ready=%b required 0 1", Valid, In_Ready);
    end
  endtask

  task automatic test_boundaries();
    int lens[8] = '{52, 55, 56, 60, 63, 64, 65, 128};
    foreach (lens[i]) begin
      rand_msg(lens[i]);
      run_message(100, 100);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      In_Valid = 1'b1; In_Last = 1'b0; In_Data = $urandom;
      @(negedge clk);
    end
    In_Valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (Valid !== 1'b0 || In_Ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset: got Valid=%b In_Ready=%b required 0 1", Valid, In_Ready);
    end
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    run_message(100, 100);
  endtask

  task automatic test_random();
    for (int m = 0; m < 25; m++) begin
      rand_msg($urandom_range(1, 200));
      run_message($urandom_range(40, 100), $urandom_range(30, 100));
    end
  endtask

  task automatic test_back_to_back();
    for (int m = 0; m < 6; m++) begin
      rand_msg($urandom_range(1, 4) + 4 * m * 5);
      run_message(100, 100);
    end
  endtask

  initial begin
    test_reset();
    test_abc_stall();
    test_boundaries();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
